// File: rtl/data_checker.sv
// Incrementing-pattern data checker: waits for a sync word, then compares a fixed-length
// run of words against seed + n*step and reports the pass/fail, error count and first mismatch.
module data_checker #(
    parameter logic [7:0] P_SEED         = 8'h01,
    parameter logic [7:0] P_STEP         = 8'h01,
    parameter int         P_LEN          = 16,
    parameter int         P_SYNC_TIMEOUT = 255
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        START_I,
    input  logic [7:0]  DATA_I,
    input  logic        VALID_I,
    output logic        READY_O,
    output logic        BUSY_O,
    output logic        DONE_O,
    output logic        PASS_O,
    output logic        TIMEOUT_O,
    output logic [15:0] ERR_CNT_O,
    output logic [15:0] WORD_CNT_O,
    output logic [7:0]  FIRST_BAD_O,
    output logic [7:0]  FIRST_EXP_O
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SYNC  = 2'd1;
    localparam logic [1:0] CHECK = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [15:0] LEN_W    = 16'(P_LEN);
    localparam logic [31:0] TMO_LAST = 32'(P_SYNC_TIMEOUT - 1);

    logic [1:0]  state;
    logic [31:0] timer;
    logic [7:0]  exp_q;
    logic        accept;
    logic        mismatch;
    logic [15:0] word_next;

    // Handshake and status outputs decode only the state register.
    assign READY_O = (state == SYNC) || (state == CHECK);
    assign BUSY_O  = (state != IDLE);
    assign DONE_O  = (state == DONE);

    assign accept    = VALID_I && READY_O;
    assign mismatch  = (DATA_I != exp_q);
    assign word_next = WORD_CNT_O + 16'd1;

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state       <= IDLE;
            timer       <= '0;
            exp_q       <= '0;
            PASS_O      <= 1'b0;
            TIMEOUT_O   <= 1'b0;
            ERR_CNT_O   <= '0;
            WORD_CNT_O  <= '0;
            FIRST_BAD_O <= '0;
            FIRST_EXP_O <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (START_I) begin
                        state       <= SYNC;
                        timer       <= '0;
                        PASS_O      <= 1'b0;
                        TIMEOUT_O   <= 1'b0;
                        ERR_CNT_O   <= '0;
                        WORD_CNT_O  <= '0;
                        FIRST_BAD_O <= '0;
                        FIRST_EXP_O <= '0;
                    end
                end
                SYNC: begin
                    timer <= timer + 32'd1;
                    // A sync word arriving on the expiry cycle still wins.
                    if (accept && DATA_I == P_SEED) begin
                        WORD_CNT_O <= 16'd1;
                        exp_q      <= P_SEED + P_STEP;
                        if (P_LEN == 1) begin
                            state  <= DONE;
                            PASS_O <= 1'b1;
                        end else begin
                            state  <= CHECK;
                        end
                    end else if (timer == TMO_LAST) begin
                        state     <= DONE;
                        TIMEOUT_O <= 1'b1;
                        PASS_O    <= 1'b0;
                    end
                end
                CHECK: begin
                    if (accept) begin
                        WORD_CNT_O <= word_next;
                        exp_q      <= exp_q + P_STEP;
                        if (mismatch) begin
                            if (ERR_CNT_O != 16'hFFFF) ERR_CNT_O <= ERR_CNT_O + 16'd1;
                            if (ERR_CNT_O == 16'd0) begin
                                FIRST_BAD_O <= DATA_I;
                                FIRST_EXP_O <= exp_q;
                            end
                        end
                        if (word_next == LEN_W) begin
                            state  <= DONE;
                            PASS_O <= !mismatch && (ERR_CNT_O == 16'd0);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_checker.sv
// Self-checking bench for data_checker: expected run results are queued as each run is
// launched and compared against the DUT outputs when its DONE_O pulse appears.
module tb_data_checker;

    typedef struct {
        logic        pass;
        logic        tmo;
        logic [15:0] err;
        logic [15:0] wc;
        logic [7:0]  fb;
        logic [7:0]  fe;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1, start_a = 1'b0, start_b = 1'b0, valid = 1'b0, sel = 1'b0;
    logic [7:0] data = 8'h00;

    logic        rdy_a, busy_a, done_a, pass_a, tmo_a;
    logic        rdy_b, busy_b, done_b, pass_b, tmo_b;
    logic [15:0] err_a, wc_a, err_b, wc_b;
    logic [7:0]  fb_a, fe_a, fb_b, fe_b;

    data_checker dut_a (
        .CLK_I(clk), .RST_I(rst), .START_I(start_a), .DATA_I(data), .VALID_I(valid),
        .READY_O(rdy_a), .BUSY_O(busy_a), .DONE_O(done_a), .PASS_O(pass_a),
        .TIMEOUT_O(tmo_a), .ERR_CNT_O(err_a), .WORD_CNT_O(wc_a),
        .FIRST_BAD_O(fb_a), .FIRST_EXP_O(fe_a)
    );

    data_checker #(.P_SEED(8'hF8)) dut_b (
        .CLK_I(clk), .RST_I(rst), .START_I(start_b), .DATA_I(data), .VALID_I(valid),
        .READY_O(rdy_b), .BUSY_O(busy_b), .DONE_O(done_b), .PASS_O(pass_b),
        .TIMEOUT_O(tmo_b), .ERR_CNT_O(err_b), .WORD_CNT_O(wc_b),
        .FIRST_BAD_O(fb_b), .FIRST_EXP_O(fe_b)
    );

    logic        o_ready, o_busy, o_done, o_pass, o_tmo;
    logic [15:0] o_err, o_wc;
    logic [7:0]  o_fb, o_fe;
    assign o_ready = sel ? rdy_b  : rdy_a;
    assign o_busy  = sel ? busy_b : busy_a;
    assign o_done  = sel ? done_b : done_a;
    assign o_pass  = sel ? pass_b : pass_a;
    assign o_tmo   = sel ? tmo_b  : tmo_a;
    assign o_err   = sel ? err_b  : err_a;
    assign o_wc    = sel ? wc_b   : wc_a;
    assign o_fb    = sel ? fb_b   : fb_a;
    assign o_fe    = sel ? fe_b   : fe_a;

    int   n_chk = 0, n_fail = 0;
    res_t sb[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic res_t mk(input logic p, input logic t, input logic [15:0] e,
                                input logic [15:0] w, input logic [7:0] b, input logic [7:0] x);
        res_t r;
        r.pass = p; r.tmo = t; r.err = e; r.wc = w; r.fb = b; r.fe = x;
        return r;
    endfunction

    task automatic start_run(input logic s);
        sel = s;
        if (s) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0; start_b = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] d);
        int g;
        g = $urandom_range(0, 2);
        repeat (g) begin @(posedge clk); #1; end
        chk("ready_before_word", o_ready, 1);
        valid = 1'b1; data = d;
        @(posedge clk); #1;
        valid = 1'b0;
    endtask

    // Called one cycle after the final accept (or timeout edge).
    task automatic check_done();
        res_t e;
        chk("done_pulse", o_done, 1);
        chk("ready_in_done", o_ready, 0);
        chk("sb_nonempty", (sb.size() > 0), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("pass", o_pass, e.pass);
            chk("timeout", o_tmo, e.tmo);
            chk("err_cnt", o_err, e.err);
            chk("word_cnt", o_wc, e.wc);
            chk("first_bad", o_fb, e.fb);
            chk("first_exp", o_fe, e.fe);
            @(posedge clk); #1;
            chk("done_single_cycle", o_done, 0);
            chk("idle_after_done", o_busy, 0);
            chk("pass_hold", o_pass, e.pass);
        end
    endtask

    task automatic run(input logic s, input logic [7:0] w[$], input res_t e);
        sb.push_back(e);
        start_run(s);
        foreach (w[i]) send_word(w[i]);
        check_done();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ramp[$], bad[$], pre[$], wrap[$];
        int  n;
        logic seen;
        for (int i = 0; i < 16; i++) begin
            ramp.push_back(8'(8'h01 + i));
            wrap.push_back(8'(8'hF8 + i));
        end
        bad = ramp;
        bad[4] = 8'hAA;
        pre = {8'h00, 8'h7F, 8'h02};
        foreach (ramp[i]) pre.push_back(ramp[i]);

        #2;
        chk("rst_busy", busy_a, 0);
        chk("rst_ready", rdy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_word_cnt", wc_a, 0);
        chk("rst_outputs_b", {busy_b, rdy_b, pass_b, tmo_b, err_b}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        run(1'b0, ramp, mk(1'b1, 1'b0, 16'd0, 16'd16, 8'h00, 8'h00));
        run(1'b0, bad,  mk(1'b0, 1'b0, 16'd1, 16'd16, 8'hAA, 8'h05));
        run(1'b0, pre,  mk(1'b1, 1'b0, 16'd0, 16'd16, 8'h00, 8'h00));

        // Sync timeout with no data offered.
        sb.push_back(mk(1'b0, 1'b1, 16'd0, 16'd0, 8'h00, 8'h00));
        start_run(1'b0);
        n = 0;
        while (n < 300 && !o_done) begin
            @(posedge clk); #1;
            n++;
        end
        chk("timeout_latency", n, 255);
        check_done();

        run(1'b1, wrap, mk(1'b1, 1'b0, 16'd0, 16'd16, 8'h00, 8'h00));

        // Abort mid-run: 8 words accepted, then reset.
        start_run(1'b0);
        for (int i = 0; i < 8; i++) send_word(ramp[i]);
        chk("mid_word_cnt", o_wc, 8);
        rst = 1'b1;
        #1;
        chk("abort_busy", o_busy, 0);
        chk("abort_ready", o_ready, 0);
        chk("abort_word_cnt", o_wc, 0);
        chk("abort_misc", {o_pass, o_tmo, o_err, o_fb, o_fe}, 0);
        seen = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) begin
            seen = seen | o_done;
            @(posedge clk); #1;
        end
        chk("abort_no_done", seen, 0);
        run(1'b0, ramp, mk(1'b1, 1'b0, 16'd0, 16'd16, 8'h00, 8'h00));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
